// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 write sequencer: state encoding,
// the power-on init byte sequence and the command bytes that need the long
// execution delay.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_LOAD  = 3'd1,
        S_SETUP = 3'd2,
        S_PULSE = 3'd3,
        S_HOLD  = 3'd4,
        S_EXEC  = 3'd5,
        S_IDLE  = 3'd6
    } state_t;

    localparam int INIT_LEN = 5;

    // Function set 8-bit/2-line, clear, display on + cursor, entry mode, DDRAM 0
    localparam logic [7:0] INIT_ROM [0:INIT_LEN-1] = '{8'h38, 8'h01, 8'h0E, 8'h06, 8'h80};

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Clear (01) and return-home (02/03) are the slow instructions; any data
    // write (rs=1) is a normal-speed write regardless of its byte value.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (!rs) && ((data & ~(CMD_CLEAR | CMD_HOME)) == 8'h00);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter used as the single phase timer of the LCD sequencer.
// Loading value V makes the phase last V+1 cycles; the count saturates at 0.
module lcd_delay_cnt #(
    parameter int CNT_W   = 8,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] count_reg;

    // Reset preloads the power-up wait so the first phase needs no explicit load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= CNT_W'(RST_VAL);
        end else if (load) begin
            count_reg <= value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - CNT_W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// Write-only HD44780 sequencer on an 8-bit bus. After reset it waits for the
// panel to power up, replays the fixed init sequence, then serves upstream
// command/data writes one at a time over a valid/ready handshake.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_PWRUP = 1500000,
    parameter int T_AS    = 2,
    parameter int T_PW    = 24,
    parameter int T_H     = 2,
    parameter int T_EXEC  = 4000,
    parameter int T_LONG  = 164000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

    localparam int T_MAX = max_int(max_int(max_int(T_PWRUP, T_AS), max_int(T_PW, T_H)),
                                   max_int(T_EXEC, T_LONG));
    localparam int CNT_W = $clog2(T_MAX) + 1;

    state_t           state_reg;
    logic [2:0]       init_idx_reg;
    logic             req_rs_reg;
    logic [7:0]       req_data_reg;
    logic             lcd_rs_reg;
    logic [7:0]       lcd_data_reg;
    logic             lcd_en_reg;
    logic             req_ready_reg;
    logic             init_done_reg;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_zero;

    lcd_delay_cnt #(
        .CNT_W   (CNT_W),
        .RST_VAL (T_PWRUP - 1)
    ) u_delay_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .value (cnt_value),
        .zero  (cnt_zero)
    );

    // Load the timer with the length of the phase being entered on each transition.
    always_comb begin
        cnt_load  = 1'b0;
        cnt_value = '0;
        case (state_reg)
            S_LOAD: begin
                cnt_load  = 1'b1;
                cnt_value = CNT_W'(T_AS - 1);
            end
            S_SETUP: begin
                cnt_load  = cnt_zero;
                cnt_value = CNT_W'(T_PW - 1);
            end
            S_PULSE: begin
                cnt_load  = cnt_zero;
                cnt_value = CNT_W'(T_H - 1);
            end
            S_HOLD: begin
                cnt_load  = cnt_zero;
                cnt_value = is_long_cmd(lcd_rs_reg, lcd_data_reg) ? CNT_W'(T_LONG - 1)
                                                                   : CNT_W'(T_EXEC - 1);
            end
            default: begin
                cnt_load  = 1'b0;
                cnt_value = '0;
            end
        endcase
    end

    // Sequencer FSM; every pin and handshake output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_PWRUP;
            init_idx_reg  <= 3'd0;
            req_rs_reg    <= 1'b0;
            req_data_reg  <= 8'h00;
            lcd_rs_reg    <= 1'b0;
            lcd_data_reg  <= 8'h00;
            lcd_en_reg    <= 1'b0;
            req_ready_reg <= 1'b0;
            init_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_PWRUP: begin
                    if (cnt_zero) state_reg <= S_LOAD;
                end
                S_LOAD: begin
                    // Bus is only ever changed here, while EN is low and before setup starts.
                    if (!init_done_reg) begin
                        lcd_rs_reg   <= 1'b0;
                        lcd_data_reg <= INIT_ROM[init_idx_reg];
                    end else begin
                        lcd_rs_reg   <= req_rs_reg;
                        lcd_data_reg <= req_data_reg;
                    end
                    state_reg <= S_SETUP;
                end
                S_SETUP: begin
                    if (cnt_zero) begin
                        lcd_en_reg <= 1'b1;
                        state_reg  <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (cnt_zero) begin
                        lcd_en_reg <= 1'b0;
                        state_reg  <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (cnt_zero) state_reg <= S_EXEC;
                end
                S_EXEC: begin
                    if (cnt_zero) begin
                        if (!init_done_reg && (init_idx_reg != 3'(INIT_LEN - 1))) begin
                            init_idx_reg <= init_idx_reg + 3'd1;
                            state_reg    <= S_LOAD;
                        end else begin
                            init_done_reg <= 1'b1;
                            req_ready_reg <= 1'b1;
                            state_reg     <= S_IDLE;
                        end
                    end
                end
                S_IDLE: begin
                    if (req_valid && req_ready_reg) begin
                        req_rs_reg    <= req_rs;
                        req_data_reg  <= req_data;
                        req_ready_reg <= 1'b0;
                        state_reg     <= S_LOAD;
                    end
                end
                default: begin
                    state_reg <= S_PWRUP;
                end
            endcase
        end
    end

    assign req_ready = req_ready_reg;
    assign init_done = init_done_reg;
    assign lcd_rs    = lcd_rs_reg;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = lcd_en_reg;
    assign lcd_data  = lcd_data_reg;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed testbench for lcd_ctrl with shortened timing
// (T_PWRUP=10, T_AS=1, T_PW=2, T_H=1, T_EXEC=4, T_LONG=8).
module tb_lcd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready;
    logic       init_done;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    logic [7:0] exp_init [0:4] = '{8'h38, 8'h01, 8'h0E, 8'h06, 8'h80};
    logic [7:0] chars    [0:6] = '{8'h76, 8'h65, 8'h72, 8'h69, 8'h6C, 8'h6F, 8'h67};

    lcd_ctrl #(
        .T_PWRUP (10),
        .T_AS    (1),
        .T_PW    (2),
        .T_H     (1),
        .T_EXEC  (4),
        .T_LONG  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .req_ready (req_ready),
        .init_done (init_done),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_data  (lcd_data)
    );

    always #5 clk = ~clk;

    // Edge counter; at each negedge it equals the index of the last rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Observe the next EN pulse: rise cycle, width, bus value, and whether
    // RS/DATA stayed put through the pulse and the first hold cycle.
    task automatic wait_pulse(output logic rs, output logic [7:0] d, output int rise,
                              output int width, output bit stable, output bit ok);
        ok = 1'b0; stable = 1'b1; width = 0; rise = 0; rs = 1'b0; d = 8'h00;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (lcd_en === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        rise = cyc; rs = lcd_rs; d = lcd_data;
        while (lcd_en === 1'b1 && width < 50) begin
            width++;
            @(negedge clk);
            if (lcd_rs !== rs || lcd_data !== d) stable = 1'b0;
        end
    endtask

    // Issue one write and measure accept-to-ready-again latency.
    task automatic do_write(input logic rs, input logic [7:0] d, output int lat, output bit ok);
        int n;
        ok = 1'b0; lat = 0;
        for (int i = 0; i < 100; i++) begin
            if (req_ready === 1'b1) break;
            @(negedge clk);
        end
        req_rs = rs; req_data = d; req_valid = 1'b1;
        n = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        lat = cyc - n;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (lcd_en !== 1'b0) $display("FAIL reset_en: got %b required 0", lcd_en); else n_pass++;
        n_checks++; if (lcd_rs !== 1'b0) $display("FAIL reset_rs: got %b required 0", lcd_rs); else n_pass++;
        n_checks++; if (lcd_rw !== 1'b0) $display("FAIL reset_rw: got %b required 0", lcd_rw); else n_pass++;
        n_checks++; if (lcd_data !== 8'h00) $display("FAIL reset_data: got %h required 00", lcd_data); else n_pass++;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL reset_ready: got %b required 0", req_ready); else n_pass++;
        n_checks++; if (init_done !== 1'b0) $display("FAIL reset_init_done: got %b required 0", init_done); else n_pass++;
    endtask

    // Release reset and verify power-up quiet time, the 5 init writes, gaps and completion.
    task automatic test_init_sequence(input string tag);
        logic       rs;
        logic [7:0] d;
        int         rise, width, r0, prev_fall, exp_gap;
        bit         stable, ok, quiet;
        rst_n = 1'b1;
        r0 = cyc; quiet = 1'b1; prev_fall = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (lcd_en !== 1'b0 || req_ready !== 1'b0 || init_done !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) $display("FAIL %s_pwrup_quiet: EN/ready/init_done active in first 10 cycles, required all 0", tag);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            wait_pulse(rs, d, rise, width, stable, ok);
            n_checks++;
            if (!ok) begin
                $display("FAIL %s_pulse%0d_seen: no EN pulse within 400 cycles, required one", tag, k);
                return;
            end
            n_pass++;
            n_checks++;
            if ({rs, d} !== {1'b0, exp_init[k]})
                $display("FAIL %s_pulse%0d_bus: got rs=%b data=%h required rs=0 data=%h", tag, k, rs, d, exp_init[k]);
            else n_pass++;
            n_checks++;
            if (width !== 2) $display("FAIL %s_pulse%0d_width: got %0d required 2", tag, k, width); else n_pass++;
            n_checks++;
            if (!stable) $display("FAIL %s_pulse%0d_stable: bus changed during EN/hold, required stable", tag, k);
            else n_pass++;
            if (k == 0) begin
                n_checks++;
                if (rise !== r0 + 12) $display("FAIL %s_first_rise: got cycle %0d required %0d", tag, rise, r0 + 12);
                else n_pass++;
            end else begin
                exp_gap = (k == 2) ? 11 : 7;
                n_checks++;
                if (rise - prev_fall !== exp_gap)
                    $display("FAIL %s_gap%0d: got %0d cycles required %0d", tag, k, rise - prev_fall, exp_gap);
                else n_pass++;
            end
            prev_fall = rise + width;
        end
        for (int i = 0; i < 50; i++) begin
            if (req_ready === 1'b1 || init_done === 1'b1) break;
            @(negedge clk);
        end
        n_checks++;
        if (init_done !== 1'b1 || req_ready !== 1'b1)
            $display("FAIL %s_done_together: got init_done=%b ready=%b required both 1", tag, init_done, req_ready);
        else n_pass++;
        n_checks++;
        if (cyc !== prev_fall + 5)
            $display("FAIL %s_done_cycle: got cycle %0d required %0d", tag, cyc, prev_fall + 5);
        else n_pass++;
    endtask

    task automatic test_single_char();
        logic       rs;
        logic [7:0] d;
        int         rise, width, n;
        bit         stable, ok;
        for (int i = 0; i < 100; i++) begin
            if (req_ready === 1'b1) break;
            @(negedge clk);
        end
        req_rs = 1'b1; req_data = 8'h76; req_valid = 1'b1;
        n = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL char_ready_drop: got %b required 0", req_ready); else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({lcd_en, lcd_rs, lcd_data} !== {1'b0, 1'b1, 8'h76})
            $display("FAIL char_setup_bus: got en=%b rs=%b data=%h required en=0 rs=1 data=76", lcd_en, lcd_rs, lcd_data);
        else n_pass++;
        wait_pulse(rs, d, rise, width, stable, ok);
        n_checks++;
        if (!ok || rise !== n + 2) $display("FAIL char_en_rise: got cycle %0d (seen=%b) required %0d", rise, ok, n + 2);
        else n_pass++;
        n_checks++;
        if (!stable || width !== 2) $display("FAIL char_pulse: got width=%0d stable=%b required width=2 stable=1", width, stable);
        else n_pass++;
        for (int i = 0; i < 50; i++) begin
            if (req_ready === 1'b1) break;
            @(negedge clk);
        end
        n_checks++;
        if (req_ready !== 1'b1 || cyc !== n + 9)
            $display("FAIL char_ready_return: got cycle %0d ready=%b required cycle %0d ready=1", cyc, req_ready, n + 9);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic       m_rs;
        logic [7:0] m_d;
        int         m_rise, m_width;
        bit         m_stable, m_ok, got, quiet;
        fork
            begin
                for (int i = 0; i < 7; i++) begin
                    req_rs = 1'b1; req_data = chars[i]; req_valid = 1'b1;
                    got = 1'b0;
                    for (int j = 0; j < 100; j++) begin
                        if (req_ready === 1'b1) begin
                            got = 1'b1;
                            break;
                        end
                        @(negedge clk);
                    end
                    @(negedge clk);
                    n_checks++;
                    if (!got || req_ready !== 1'b0)
                        $display("FAIL b2b_ready%0d: seen=%b ready after accept=%b required seen=1 ready=0", i, got, req_ready);
                    else n_pass++;
                end
                req_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 7; k++) begin
                    wait_pulse(m_rs, m_d, m_rise, m_width, m_stable, m_ok);
                    n_checks++;
                    if (!m_ok || {m_rs, m_d} !== {1'b1, chars[k]})
                        $display("FAIL b2b_pulse%0d: seen=%b rs=%b data=%h required rs=1 data=%h", k, m_ok, m_rs, m_d, chars[k]);
                    else n_pass++;
                end
            end
        join
        quiet = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (lcd_en !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) $display("FAIL b2b_no_extra: got an extra EN pulse, required none"); else n_pass++;
    endtask

    task automatic test_exec_delay();
        int lat;
        bit ok;
        do_write(1'b0, 8'h01, lat, ok);
        n_checks++;
        if (!ok || lat !== 13) $display("FAIL exec_clear: got latency %0d (ok=%b) required 13", lat, ok); else n_pass++;
        do_write(1'b1, 8'h01, lat, ok);
        n_checks++;
        if (!ok || lat !== 9) $display("FAIL exec_data01: got latency %0d (ok=%b) required 9", lat, ok); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        for (int i = 0; i < 100; i++) begin
            if (req_ready === 1'b1) break;
            @(negedge clk);
        end
        req_rs = 1'b1; req_data = 8'h41; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (lcd_en === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL midrst_en_high: EN not seen high, required 1"); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({lcd_en, lcd_rs, lcd_rw, lcd_data, req_ready, init_done} !== 13'b0)
            $display("FAIL midrst_async: got en=%b rs=%b rw=%b data=%h ready=%b done=%b required all 0",
                     lcd_en, lcd_rs, lcd_rw, lcd_data, req_ready, init_done);
        else n_pass++;
        repeat (3) @(negedge clk);
        test_init_sequence("reinit");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_init_sequence("init");
        test_single_char();
        test_back_to_back();
        test_exec_delay();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
